// File: rtl/vram_pkg.sv
// Shared types and widths for the video/data RAM arbiter.
`timescale 1ns/1ps
package vram_pkg;
    localparam int VRAM_ADDR_W = 8;
    localparam int VRAM_DATA_W = 8;

    typedef enum logic [1:0] {IDLE, V_WAIT, C_WAIT} vram_state_t;
endpackage

// File: rtl/vram_arbiter.sv
// Shares the single-port video/data RAM between the CPU data port and VGA scanout.
// VGA refetches its held tile byte on address change and wins ties; CPU uses every other slot.
`timescale 1ns/1ps
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    vram_state_t       state, state_nxt;
    logic [ADDR_W-1:0] vga_tag;
    logic              vga_valid;
    logic              vga_pending;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic              cpu_rd_q;
    logic              vga_issue, cpu_issue;

    assign vga_pending = !vga_valid || (vga_addr != vga_tag);

    // Outputs are forced quiet while reset is held, even before the state register clears.
    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_ack   = 1'b0;
        vga_issue = 1'b0;
        cpu_issue = 1'b0;
        if (reset) begin
            case (state)
                IDLE: begin
                    if (vga_pending) begin
                        mem_en    = 1'b1;
                        mem_addr  = vga_addr;
                        vga_issue = 1'b1;
                        state_nxt = V_WAIT;
                    end else if (cpu_req) begin
                        mem_en    = 1'b1;
                        mem_we    = cpu_we;
                        mem_addr  = cpu_addr;
                        mem_wdata = cpu_wdata;
                        cpu_issue = 1'b1;
                        state_nxt = C_WAIT;
                    end
                end
                V_WAIT:  state_nxt = IDLE;
                C_WAIT: begin
                    cpu_ack   = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            vga_tag     <= '0;
            vga_valid   <= 1'b0;
            vga_data    <= '0;
            cpu_rdata_q <= '0;
            cpu_rd_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (vga_issue)
                vga_tag <= vga_addr;
            if (cpu_issue)
                cpu_rd_q <= !cpu_we;
            // The byte for the latched tag is stored even if vga_addr moved meanwhile.
            if (state == V_WAIT) begin
                vga_data  <= mem_rdata;
                vga_valid <= 1'b1;
            end
            if (state == C_WAIT && cpu_rd_q)
                cpu_rdata_q <= mem_rdata;
        end
    end

    // Read data is passed through in the ack cycle and held afterwards.
    assign cpu_rdata = (reset && state == C_WAIT && cpu_rd_q) ? mem_rdata : cpu_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized self-checking bench for vram_arbiter against a flat golden memory model.
`timescale 1ns/1ps
module tb_vram_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       cpu_ack;
    logic [7:0] vga_addr, vga_data;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata = 8'h00;

    logic [7:0] ram  [256];
    logic [7:0] gold [256];
    logic       load;
    int         pass_cnt = 0;
    int         total_cnt = 0;
    logic       frame_on;

    always #5 clk = ~clk;

    vram_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vga_addr(vga_addr), .vga_data(vga_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Synchronous single-port RAM, registered read.
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) ram[i] <= gold[i];
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    // Holds a request until ack (bounded); returns read data and cycles from request to ack.
    task automatic cpu_access(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                              output logic [7:0] rd, output int lat);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        lat = -1; rd = 8'hxx;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (cpu_ack === 1'b1) begin
                lat = n; rd = cpu_rdata;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        cpu_req = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk); #1;
        total_cnt += 7;
        if (cpu_ack !== 1'b0)   $display("FAIL reset_ack got %0b want 0", cpu_ack);     else pass_cnt++;
        if (mem_en !== 1'b0)    $display("FAIL reset_mem_en got %0b want 0", mem_en);   else pass_cnt++;
        if (mem_we !== 1'b0)    $display("FAIL reset_mem_we got %0b want 0", mem_we);   else pass_cnt++;
        if (mem_addr !== 8'h0)  $display("FAIL reset_mem_addr got %h want 00", mem_addr);   else pass_cnt++;
        if (mem_wdata !== 8'h0) $display("FAIL reset_mem_wdata got %h want 00", mem_wdata); else pass_cnt++;
        if (vga_data !== 8'h0)  $display("FAIL reset_vga_data got %h want 00", vga_data);   else pass_cnt++;
        if (cpu_rdata !== 8'h0) $display("FAIL reset_cpu_rdata got %h want 00", cpu_rdata); else pass_cnt++;
    endtask

    task automatic test_first_fetch;
        int fetches;
        @(negedge clk);
        reset = 1'b1;
        #1;
        total_cnt += 5;
        if (!(mem_en === 1'b1 && mem_we === 1'b0 && mem_addr === 8'h80))
            $display("FAIL first_fetch_issue got en=%b we=%b addr=%h want 1/0/80", mem_en, mem_we, mem_addr);
        else pass_cnt++;
        @(negedge clk); #1;
        if (mem_en !== 1'b0) $display("FAIL first_fetch_vwait_en got %b want 0", mem_en); else pass_cnt++;
        @(negedge clk); #1;
        if (vga_data !== 8'h2A) $display("FAIL first_fetch_data got %h want 2a", vga_data); else pass_cnt++;
        if (mem_en !== 1'b0) $display("FAIL first_fetch_idle_en got %b want 0", mem_en); else pass_cnt++;
        fetches = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (mem_en === 1'b1) fetches++;
        end
        if (fetches != 0) $display("FAIL stable_no_refetch got %0d want 0", fetches); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_cpu_rw;
        logic [7:0] rd; int lat;
        cpu_access(1'b1, 8'h10, 8'h55, rd, lat);
        gold[8'h10] = 8'h55;
        total_cnt += 3;
        if (lat != 1) $display("FAIL write_latency got %0d want 1", lat); else pass_cnt++;
        cpu_access(1'b0, 8'h10, 8'h00, rd, lat);
        if (lat != 1) $display("FAIL read_latency got %0d want 1", lat); else pass_cnt++;
        if (rd !== 8'h55) $display("FAIL read_after_write got %h want 55", rd); else pass_cnt++;
    endtask

    task automatic test_vga_priority;
        logic [7:0] rd; int lat;
        vga_addr = 8'h88;
        cpu_access(1'b0, 8'h20, 8'h00, rd, lat);
        total_cnt += 3;
        if (lat != 3) $display("FAIL priority_cpu_latency got %0d want 3", lat); else pass_cnt++;
        if (rd !== gold[8'h20]) $display("FAIL priority_cpu_data got %h want %h", rd, gold[8'h20]); else pass_cnt++;
        if (vga_data !== gold[8'h88]) $display("FAIL priority_vga_data got %h want %h", vga_data, gold[8'h88]); else pass_cnt++;
    endtask

    task automatic test_vga_change_in_wait;
        vga_addr = 8'h80;
        repeat (4) @(negedge clk);
        vga_addr = 8'h88;
        #1;
        total_cnt += 5;
        if (!(mem_en === 1'b1 && mem_addr === 8'h88))
            $display("FAIL chg_issue got en=%b addr=%h want 1/88", mem_en, mem_addr);
        else pass_cnt++;
        @(negedge clk);
        vga_addr = 8'h90;
        #1;
        if (mem_en !== 1'b0) $display("FAIL chg_vwait_en got %b want 0", mem_en); else pass_cnt++;
        @(negedge clk); #1;
        if (vga_data !== gold[8'h88]) $display("FAIL chg_old_byte got %h want %h", vga_data, gold[8'h88]); else pass_cnt++;
        if (!(mem_en === 1'b1 && mem_addr === 8'h90))
            $display("FAIL chg_refetch got en=%b addr=%h want 1/90", mem_en, mem_addr);
        else pass_cnt++;
        @(negedge clk);
        @(negedge clk); #1;
        if (vga_data !== gold[8'h90]) $display("FAIL chg_new_byte got %h want %h", vga_data, gold[8'h90]); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_in_cwait;
        logic [7:0] rd; int lat;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 8'hC3;
        #1;
        total_cnt += 8;
        if (!(mem_en === 1'b1 && mem_we === 1'b1))
            $display("FAIL rst_cw_issue got en=%b we=%b want 1/1", mem_en, mem_we);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        if (cpu_ack !== 1'b0) $display("FAIL rst_cw_no_ack got %b want 0", cpu_ack); else pass_cnt++;
        @(negedge clk); #1;
        if (vga_data !== 8'h00) $display("FAIL rst_cw_vga_data got %h want 00", vga_data); else pass_cnt++;
        if (mem_en !== 1'b0 || cpu_ack !== 1'b0)
            $display("FAIL rst_cw_quiet got en=%b ack=%b want 0/0", mem_en, cpu_ack);
        else pass_cnt++;
        reset = 1'b1;
        #1;
        if (!(mem_en === 1'b1 && mem_we === 1'b0 && mem_addr === vga_addr))
            $display("FAIL rst_cw_vga_first got en=%b we=%b addr=%h want 1/0/%h", mem_en, mem_we, mem_addr, vga_addr);
        else pass_cnt++;
        lat = -1;
        for (int n = 0; n < 20; n++) begin
            if (cpu_ack === 1'b1) begin lat = n; break; end
            @(negedge clk); #1;
        end
        if (lat != 3) $display("FAIL rst_cw_reissue_latency got %0d want 3", lat); else pass_cnt++;
        gold[8'h30] = 8'hC3;
        @(negedge clk);
        cpu_req = 1'b0;
        cpu_access(1'b0, 8'h30, 8'h00, rd, lat);
        if (rd !== 8'hC3) $display("FAIL rst_cw_readback got %h want c3", rd); else pass_cnt++;
        if (vga_data !== gold[vga_addr]) $display("FAIL rst_cw_vga_refill got %h want %h", vga_data, gold[vga_addr]); else pass_cnt++;
    endtask

    // Scaled-down frame: tile address moves every 64 clocks while CPU traffic runs back to back
    // in the low half of memory, so the tile region stays constant in the golden model.
    task automatic test_back_to_back;
        int vga_bad, lat_bad, data_bad, n_acc;
        vga_bad = 0; lat_bad = 0; data_bad = 0; n_acc = 0;
        frame_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    repeat (64) @(negedge clk);
                    vga_addr = 8'h80 | 8'($urandom_range(0, 127));
                end
                frame_on = 1'b0;
            end
            begin
                logic [7:0] rd, a, wd; logic we; int lat;
                while (frame_on) begin
                    we = 1'($urandom_range(0, 1));
                    a  = 8'($urandom_range(0, 127));
                    wd = 8'($urandom);
                    cpu_access(we, a, wd, rd, lat);
                    n_acc++;
                    if (lat < 1 || lat > 3) begin
                        lat_bad++;
                        if (lat_bad < 5) $display("FAIL frame_cpu_wait got %0d want 1..3", lat);
                    end
                    if (we) gold[a] = wd;
                    else if (rd !== gold[a]) begin
                        data_bad++;
                        if (data_bad < 5) $display("FAIL frame_cpu_rdata addr %h got %h want %h", a, rd, gold[a]);
                    end
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                end
            end
            begin
                logic [7:0] prev; int stable;
                prev = vga_addr; stable = 0;
                while (frame_on) begin
                    @(negedge clk); #2;
                    if (vga_addr != prev) begin stable = 0; prev = vga_addr; end
                    else stable++;
                    if (stable >= 4 && vga_data !== gold[vga_addr]) begin
                        vga_bad++;
                        if (vga_bad < 5) $display("FAIL frame_vga_data addr %h got %h want %h", vga_addr, vga_data, gold[vga_addr]);
                    end
                end
            end
        join
        total_cnt += 4;
        if (lat_bad != 0)  $display("FAIL frame_wait_count got %0d want 0", lat_bad);  else pass_cnt++;
        if (data_bad != 0) $display("FAIL frame_rdata_count got %0d want 0", data_bad); else pass_cnt++;
        if (vga_bad != 0)  $display("FAIL frame_vga_count got %0d want 0", vga_bad);   else pass_cnt++;
        if (n_acc < 100)   $display("FAIL frame_accesses got %0d want >=100", n_acc);  else pass_cnt++;
    endtask

    initial begin
        reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h0; cpu_wdata = 8'h0;
        vga_addr = 8'h80; frame_on = 1'b0;
        for (int i = 0; i < 256; i++) gold[i] = 8'($urandom);
        gold[8'h80] = 8'h2A; gold[8'h88] = 8'h11; gold[8'h90] = 8'h99;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        test_reset();
        test_first_fetch();
        test_cpu_rw();
        test_vga_priority();
        test_vga_change_in_wait();
        test_reset_in_cwait();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
